// File: rtl/cpi_a2f_conn_ctrl.sv
// cpi_a2f_conn_ctrl: agent-side CPI global sideband connection controller
// sequences connect/disconnect, tracks epochs and escalates errors to sticky fatal/viral
module cpi_a2f_conn_ctrl #(
   parameter int EPOCH_ID_WIDTH = 10,
   parameter int ACK_TIMEOUT    = 1024
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      link_en_i,
   input  logic                      tx_idle_i,
   input  logic                      fatal_err_i,
   input  logic                      viral_err_i,
   input  logic                      rxcon_ack_i,
   input  logic                      rxdiscon_nack_i,
   input  logic                      rx_empty_i,
   output logic                      txcon_req_o,
   output logic                      fatal_o,
   output logic                      viral_o,
   output logic [EPOCH_ID_WIDTH-1:0] epoch_id_o,
   output logic [EPOCH_ID_WIDTH-1:0] epoch_commit_o,
   output logic [EPOCH_ID_WIDTH-1:0] epoch_reject_o,
   output logic                      tx_ready_o,
   output logic                      timeout_o,
   output logic [2:0]                state_o
);
   localparam int TW = $clog2(ACK_TIMEOUT);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CONNECTING = 3'd1;
   localparam logic [2:0] S_CONNECTED = 3'd2;
   localparam logic [2:0] S_DISCONNECTING = 3'd3;
   localparam logic [2:0] S_FATAL = 3'd4;
   localparam logic [TW-1:0] T_MAX = TW'(ACK_TIMEOUT - 1);
   localparam logic [EPOCH_ID_WIDTH-1:0] E_MAX = '1;

   logic [2:0]                state_q, state_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic [EPOCH_ID_WIDTH-1:0] epoch_q, epoch_d, commit_q, commit_d, reject_q, reject_d;
   logic                      fatal_q, fatal_d, viral_q, viral_d, timeout_q, timeout_d;
   logic                      txcon_q, txcon_d, ready_q, ready_d;
   logic                      expired, counting;

   assign expired  = timer_q == T_MAX;
   assign counting = state_q == S_CONNECTING || state_q == S_DISCONNECTING;

   always_comb begin
      state_d   = state_q;
      epoch_d   = epoch_q;
      commit_d  = commit_q;
      reject_d  = reject_q;
      fatal_d   = fatal_q;
      viral_d   = viral_q | viral_err_i;
      timeout_d = 1'b0;
      if (fatal_err_i) begin
         state_d = S_FATAL;
         fatal_d = 1'b1;
         viral_d = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: if (link_en_i && !rxcon_ack_i && !fatal_q) begin
               state_d = S_CONNECTING;
               // epoch 0 means "no epoch", so the count wraps back to 1
               epoch_d = (epoch_q == E_MAX) ? EPOCH_ID_WIDTH'(1) : epoch_q + EPOCH_ID_WIDTH'(1);
            end
            S_CONNECTING: if (rxcon_ack_i) begin
               state_d  = S_CONNECTED;
               commit_d = epoch_q;
            end else if (expired) begin
               state_d   = S_IDLE;
               reject_d  = epoch_q;
               timeout_d = 1'b1;
            end
            S_CONNECTED: if (!rxcon_ack_i) begin
               state_d = S_FATAL;
               fatal_d = 1'b1;
               viral_d = 1'b1;
            end else if (!link_en_i && tx_idle_i) state_d = S_DISCONNECTING;
            S_DISCONNECTING: if (rxdiscon_nack_i) state_d = S_CONNECTED;
            else if (!rxcon_ack_i && rx_empty_i) state_d = S_IDLE;
            else if (expired) begin
               state_d   = S_FATAL;
               fatal_d   = 1'b1;
               timeout_d = 1'b1;
            end
            default: state_d = S_FATAL;
         endcase
      end
      timer_d = (state_d != state_q) ? '0 : (counting && !expired) ? timer_q + TW'(1) : timer_q;
      txcon_d = state_d == S_CONNECTING || state_d == S_CONNECTED;
      ready_d = state_d == S_CONNECTED;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         epoch_q   <= '0;
         commit_q  <= '0;
         reject_q  <= '0;
         fatal_q   <= 1'b0;
         viral_q   <= 1'b0;
         timeout_q <= 1'b0;
         txcon_q   <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         epoch_q   <= epoch_d;
         commit_q  <= commit_d;
         reject_q  <= reject_d;
         fatal_q   <= fatal_d;
         viral_q   <= viral_d;
         timeout_q <= timeout_d;
         txcon_q   <= txcon_d;
         ready_q   <= ready_d;
      end
   end

   assign txcon_req_o    = txcon_q;
   assign tx_ready_o     = ready_q;
   assign fatal_o        = fatal_q;
   assign viral_o        = viral_q;
   assign timeout_o      = timeout_q;
   assign epoch_id_o     = epoch_q;
   assign epoch_commit_o = commit_q;
   assign epoch_reject_o = reject_q;
   assign state_o        = state_q;
endmodule
